sqrt_reconstruct: RTL and testbench
===================================

Name: sqrt_reconstruct

Overview:
Sequential inverse of the square-root unit. It takes a root Q and a remainder R and rebuilds the radicand D = Q*Q + R using an iterative shift-add multiply. It sits on the Result/Reminder side of the root datapath, where it is used for self-check and for round-trip verification. It uses the same start/Ready handshake style as the root unit.

Parameters:
DW, 16, operand/result width (mirrors mdr_pkg::DW; the package value governs)
CW, $clog2(DW)+1, iteration counter width (derived; not overridden)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset; sampled on rising edge of clk
start  input  1  request; sampled only in IDLE
Root  input  DW  root Q, unsigned
Rem  input  DW  remainder R, two's complement signed (an uncorrected negative remainder is legal)
Data_out  output  DW  low DW bits of Q*Q + R
Overflow  output  1  1 when Q*Q + R < 0 or > 2^DW-1
Busy  output  1  high from LOAD through ADD
Ready  output  1  one-cycle pulse in DONE; Data_out/Overflow valid from that cycle on

Behaviour:
- Reset (rst=0 at a clock edge):
  - FSM goes to IDLE.
  - Data_out=0, Overflow=0, Busy=0, Ready=0.
  - Accumulator, operand and counter registers clear.
  - Reset wins over any other activity, including mid-operation; the aborted result is discarded.
- FSM states: IDLE, LOAD, MULT, ADD, DONE.
  - IDLE: start=1 -> LOAD; otherwise stay.
  - LOAD: capture Root into the multiplicand (2*DW bits, zero-extended) and into the multiplier (DW bits). Capture Rem sign-extended to 2*DW+1 bits. Clear the accumulator (2*DW+1 bits) and the counter. -> MULT.
  - MULT: one iteration per cycle.
    - If multiplier[0]=1, acc += multiplicand.
    - Shift the multiplicand left 1 and the multiplier right 1; counter += 1.
    - After exactly DW iterations (counter reaches DW-1 at the edge) -> ADD.
    - No early exit when the multiplier becomes zero; latency is fixed.
  - ADD: acc += sign-extended Rem (signed 2*DW+1-bit add). -> DONE.
  - DONE:
    - Data_out <= acc[DW-1:0].
    - Overflow <= acc[2*DW] | (|acc[2*DW-1:DW]); this catches both a negative result and a result too large for DW bits.
    - Ready=1 for this cycle only. -> IDLE.
- Latency: start sampled high at edge N gives Ready high in cycle N+DW+3 (LOAD 1, MULT DW, ADD 1, DONE 1). For DW=16, that is 19 cycles.
- Output hold: Data_out and Overflow are updated only in DONE. They hold until the next DONE or reset. They do not change during a new operation.
- Start timing: start is ignored in LOAD, MULT, ADD and DONE. It is not queued. start held high continuously restarts one cycle after DONE, at the next IDLE sample.
- Operand timing: Root and Rem are sampled only in LOAD. Changes after LOAD do not affect the running operation.
- Q*Q with Q <= 2^DW-1 always fits in 2*DW bits. The extra sign bit covers only the Rem addition.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 -> Data_out=0x0000, Overflow=0, Busy=0, Ready=0. Release rst -> Busy rises one cycle later.
- Basic: Root=0x000B, Rem=0x0005, pulse start -> Ready exactly 19 cycles after the start edge, Data_out=0x007E (126), Overflow=0. Busy is high for exactly 18 cycles.
- Max in range: Root=0x00FF, Rem=0x01FE -> Data_out=0xFFFF, Overflow=0.
- Overflow and negative cases:
  - Root=0x0100, Rem=0x0000 -> Data_out=0x0000, Overflow=1.
  - Root=0x0004, Rem=0xFFFF (-1) -> Data_out=0x000F, Overflow=0.
  - Root=0x0000, Rem=0xFFFF -> Data_out=0xFFFF, Overflow=1.
- Handshake:
  - Pulse start again and change Root/Rem 3 cycles into MULT -> no restart, and the result matches the originally captured operands.
  - Hold start high continuously -> back-to-back Ready pulses spaced 20 cycles apart.
- Reset mid-operation: assert rst=0 during MULT iteration 7 -> next cycle IDLE, outputs zero, no Ready pulse. A new start after release gives the correct result with full latency.

Source files
------------

// File: rtl/sqrt_reconstruct.sv
// Rebuilds a radicand D = Q*Q + R from a square-root result using a fixed-latency
// shift-add multiply followed by a signed remainder add.
module sqrt_reconstruct #(
    parameter int unsigned DW = 16,
    localparam int unsigned CW = $clog2(DW) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] Root,
    input  logic [DW-1:0] Rem,
    output logic [DW-1:0] Data_out,
    output logic          Overflow,
    output logic          Busy,
    output logic          Ready
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMult,
        StAdd,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [2*DW-1:0] mcand_q, mcand_d;
    logic [DW-1:0]   mplier_q, mplier_d;
    logic [2*DW:0]   rem_q, rem_d;
    logic [2*DW:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   data_q, data_d;
    logic            ovf_q, ovf_d;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                mcand_d  = {{DW{1'b0}}, Root};
                mplier_d = Root;
                rem_d    = {{(DW + 1){Rem[DW-1]}}, Rem};
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = StMult;
            end
            StMult: begin
                if (mplier_q[0]) acc_d = acc_q + {1'b0, mcand_q};
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Fixed DW iterations; no early exit on a zero multiplier.
                if (cnt_q == CW'(DW - 1)) state_d = StAdd;
            end
            StAdd: begin
                acc_d   = acc_q + rem_q;
                // Outputs are registered alongside the final sum so they are
                // already valid during the DONE cycle that pulses Ready.
                data_d  = acc_d[DW-1:0];
                ovf_d   = acc_d[2*DW] | (|acc_d[2*DW-1:DW]);
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Data_out = data_q;
    assign Overflow = ovf_q;
    assign Busy     = (state_q == StLoad) || (state_q == StMult) || (state_q == StAdd);
    assign Ready    = (state_q == StDone);

endmodule

// File: tb/tb_sqrt_reconstruct.sv
// Randomised and directed checks of sqrt_reconstruct against a plain-arithmetic
// model of Q*Q + R.
module tb_sqrt_reconstruct;

    localparam int unsigned DW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] Root;
    logic [DW-1:0] Rem;
    logic [DW-1:0] Data_out;
    logic          Overflow;
    logic          Busy;
    logic          Ready;

    int n_checks = 0;
    int n_fail   = 0;

    sqrt_reconstruct #(.DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .Root     (Root),
        .Rem      (Rem),
        .Data_out (Data_out),
        .Overflow (Overflow),
        .Busy     (Busy),
        .Ready    (Ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input logic [DW-1:0] q, input logic [DW-1:0] r,
                                  output logic [DW-1:0] d, output logic o);
        longint e;
        e = longint'(q) * longint'(q) + longint'($signed(r));
        d = e[DW-1:0];
        o = (e < 0) || (e > 65535);
    endfunction

    // Pulses start and waits for Ready; lat is the cycle number (LOAD = 1) holding Ready.
    task automatic run_op(input logic [DW-1:0] q, input logic [DW-1:0] r,
                          output int lat, output int busy_cnt, output logic got);
        @(negedge clk);
        Root  = q;
        Rem   = r;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        got      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Busy) busy_cnt++;
            if (Ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        Root  = 16'h0000;
        Rem   = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (Data_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0000", Data_out);
        end
        n_checks++;
        if (Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b want 0", Overflow);
        end
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 0", Busy);
        end
        n_checks++;
        if (Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 0", Ready);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_busy: got %b want 1", Busy);
        end
        for (int i = 0; i < 30 && !Ready; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_basic;
        int   lat, bc;
        logic got;
        run_op(16'h000B, 16'h0005, lat, bc, got);
        n_checks++;
        if (!got || lat != DW + 3) begin
            n_fail++;
            $display("FAIL basic_latency: got ready=%b cycle %0d want cycle %0d", got, lat, DW + 3);
        end
        n_checks++;
        if (bc != DW + 2) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d want %0d", bc, DW + 2);
        end
        n_checks++;
        if (Data_out !== 16'h007E || Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got %h/%b want 007e/0", Data_out, Overflow);
        end
    endtask

    task automatic test_boundaries;
        logic [DW-1:0] q_tab[4] = '{16'h00FF, 16'h0100, 16'h0004, 16'h0000};
        logic [DW-1:0] r_tab[4] = '{16'h01FE, 16'h0000, 16'hFFFF, 16'hFFFF};
        logic [DW-1:0] d_tab[4] = '{16'hFFFF, 16'h0000, 16'h000F, 16'hFFFF};
        logic          o_tab[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int   lat, bc;
        logic got;
        for (int i = 0; i < 4; i++) begin
            run_op(q_tab[i], r_tab[i], lat, bc, got);
            n_checks++;
            if (!got || Data_out !== d_tab[i] || Overflow !== o_tab[i]) begin
                n_fail++;
                $display("FAIL boundary_%0d: got ready=%b %h/%b want %h/%b",
                         i, got, Data_out, Overflow, d_tab[i], o_tab[i]);
            end
        end
    endtask

    task automatic test_random;
        int            lat, bc;
        logic          got, eo;
        logic [DW-1:0] q, r, ed;
        for (int i = 0; i < 30; i++) begin
            q = (i % 2 == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom);
            r = (i % 3 == 0) ? DW'($urandom) : DW'($urandom_range(0, 511));
            model(q, r, ed, eo);
            run_op(q, r, lat, bc, got);
            n_checks++;
            if (!got || lat != DW + 3 || Data_out !== ed || Overflow !== eo) begin
                n_fail++;
                $display("FAIL random_%0d q=%h r=%h: got ready=%b cyc=%0d %h/%b want cyc=%0d %h/%b",
                         i, q, r, got, lat, Data_out, Overflow, DW + 3, ed, eo);
            end
        end
    endtask

    task automatic test_restart_ignored;
        int            lat;
        logic          got, eo, extra;
        logic [DW-1:0] ed;
        model(16'h0123, 16'h8001, ed, eo);
        @(negedge clk);
        Root  = 16'h0123;
        Rem   = 16'h8001;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        got   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            // Cycle 4 is the third MULT cycle: disturb operands and start.
            if (lat == 4) begin
                Root  = 16'hFFFF;
                Rem   = 16'h7FFF;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (Ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (!got || lat != DW + 3) begin
            n_fail++;
            $display("FAIL restart_latency: got ready=%b cycle %0d want %0d", got, lat, DW + 3);
        end
        n_checks++;
        if (Data_out !== ed || Overflow !== eo) begin
            n_fail++;
            $display("FAIL restart_result: got %h/%b want %h/%b", Data_out, Overflow, ed, eo);
        end
        extra = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (Ready || Busy) extra = 1'b1;
        end
        n_checks++;
        if (extra !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_not_queued: got activity=%b want 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        int   gap;
        logic got;
        @(negedge clk);
        Root  = 16'h0003;
        Rem   = 16'h0001;
        start = 1'b1;
        got   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Ready) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got || Data_out !== 16'h000A) begin
            n_fail++;
            $display("FAIL b2b_first: got ready=%b data=%h want 1/000a", got, Data_out);
        end
        gap = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            gap++;
            if (Ready) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        n_checks++;
        if (!got || gap != DW + 4) begin
            n_fail++;
            $display("FAIL b2b_spacing: got ready=%b gap %0d want %0d", got, gap, DW + 4);
        end
        n_checks++;
        if (Data_out !== 16'h000A || Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: got %h/%b want 000a/0", Data_out, Overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        int            lat, bc;
        logic          got, eo, seen;
        logic [DW-1:0] ed;
        @(negedge clk);
        Root  = 16'h00F0;
        Rem   = 16'h0011;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        // Cycle 1 is LOAD, so MULT iteration 7 is cycle 8.
        repeat (7) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (Busy !== 1'b0 || Ready !== 1'b0 || Data_out !== 16'h0000 || Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: got busy=%b ready=%b %h/%b want 0 0 0000/0",
                     Busy, Ready, Data_out, Overflow);
        end
        rst  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (Ready || Busy) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_ready: got activity=%b want 0", seen);
        end
        model(16'h1234, 16'h0042, ed, eo);
        run_op(16'h1234, 16'h0042, lat, bc, got);
        n_checks++;
        if (!got || lat != DW + 3 || Data_out !== ed || Overflow !== eo) begin
            n_fail++;
            $display("FAIL midreset_rerun: got ready=%b cyc=%0d %h/%b want cyc=%0d %h/%b",
                     got, lat, Data_out, Overflow, DW + 3, ed, eo);
        end
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        Root  = '0;
        Rem   = '0;
        test_reset();
        test_basic();
        test_boundaries();
        test_random();
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
